// File: rtl/split_reg_pkg.sv
// split_reg_pkg: bus widths, state encoding and sizing helpers shared by the splitter.
package split_reg_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_e;
  function automatic int req_w(input int aw, input int dw);
    return 1 + aw + dw + dw / 8;
  endfunction
  function automatic int resp_w(input int dw);
    return dw + 1;
  endfunction
  function automatic int sel_w(input int n);
    return n <= 2 ? 1 : $clog2(n);
  endfunction
  function automatic int cnt_w(input int t);
    return t <= 2 ? 1 : $clog2(t);
  endfunction
endpackage

// File: rtl/split_reg_timer.sv
// split_reg_timer: counts cycles spent waiting on a slave and flags the last allowed one.
module split_reg_timer import split_reg_pkg::*; #(
  parameter int TIMEOUT = 256
)(
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= i_en ? r_cnt + 1'b1 : '0;
  assign o_expired = (TIMEOUT != 0) && i_en && (r_cnt == LAST);
endmodule

// File: rtl/split_reg.sv
// split_reg: registered one-master-to-N-slaves address splitter with decode-error and
// timeout protection; the route stays locked until the selected slave answers.
module split_reg import split_reg_pkg::*; #(
  parameter int N_SLAVES = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int TIMEOUT  = 256
)(
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [req_w(ADDR_W, DATA_W)-1:0]          m_req,
  output logic [resp_w(DATA_W)-1:0]                 m_resp,
  output logic [N_SLAVES*req_w(ADDR_W, DATA_W)-1:0] s_req,
  input  logic [N_SLAVES*resp_w(DATA_W)-1:0]        s_resp,
  input  logic                                     err_clr,
  output logic [1:0]                               err
);
  localparam int REQ_W  = req_w(ADDR_W, DATA_W);
  localparam int RESP_W = resp_w(DATA_W);
  localparam int NS     = sel_w(N_SLAVES);
  localparam int NP     = 2 ** NS;
  localparam logic [NS:0] NSL = N_SLAVES[NS:0];
  state_e r_state, w_next;
  logic [REQ_W-1:0]  r_req;
  logic [NS-1:0]     r_sel, w_sel;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_err, w_err_set;
  logic              w_valid, w_dec_err, w_ack, w_expired;
  logic [RESP_W-1:0] w_resp [NP];
  assign w_valid   = m_req[REQ_W-1];
  // the select field is the top of the address, which sits just below valid
  assign w_sel     = m_req[REQ_W-2 -: NS];
  assign w_dec_err = {1'b0, w_sel} >= NSL;
  assign w_ack     = w_resp[r_sel][0];
  assign w_err_set = {r_state == REQ && !w_ack && w_expired,
                      r_state == IDLE && w_valid && w_dec_err};
  assign err       = r_err;
  for (genvar g = 0; g < NP; g++) begin : g_slot
    if (g < N_SLAVES) begin : g_real
      assign w_resp[g] = s_resp[g*RESP_W +: RESP_W];
      assign s_req[g*REQ_W +: REQ_W] = (r_state == REQ && r_sel == NS'(g)) ? r_req : '0;
    end else begin : g_pad
      assign w_resp[g] = '0;
    end
  end
  split_reg_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (r_state == REQ),
    .o_expired (w_expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (w_valid ? (w_dec_err ? RESP : REQ) : IDLE) :
             r_state == REQ  ? ((w_ack || w_expired) ? RESP : REQ) : IDLE;
  always_comb
    m_resp = r_state == RESP ? {r_rdata, 1'b1} : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_req   <= '0;
      r_sel   <= '0;
      r_rdata <= '0;
      r_err   <= '0;
    end else begin
      if (r_state == IDLE && w_valid) begin
        r_req <= m_req;
        r_sel <= w_sel;
      end
      r_rdata <= w_err_set[0]                ? '0 :
                 (r_state == REQ && w_ack)   ? w_resp[r_sel][RESP_W-1:1] :
                 w_err_set[1]                ? '1 : r_rdata;
      // a new event in the same cycle as err_clr keeps its flag set
      r_err   <= (r_err & {2{~err_clr}}) | w_err_set;
    end
endmodule

// File: tb/tb_split_reg.sv
// tb_split_reg: table-driven transactions with a scoreboard queue checked by a response monitor.
module tb_split_reg;
  localparam int N = 3, AW = 32, DW = 32, TO = 8;
  localparam int REQ_W = 1 + AW + DW + DW / 8, RESP_W = DW + 1;
  typedef struct {
    logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
    int slot; int dly; logic [31:0] rdata; logic [1:0] exp_err; int lat; int vc;
  } vec_t;
  typedef struct {
    int slot; logic [REQ_W-1:0] req; logic [31:0] rdata; logic [1:0] err; int cyc; int vc;
  } exp_t;
  logic clk = 0, rst_n = 0, err_clr = 0;
  logic [REQ_W-1:0]    m_req = '0;
  logic [RESP_W-1:0]   m_resp;
  logic [N*REQ_W-1:0]  s_req;
  logic [N*RESP_W-1:0] s_resp = '0;
  logic [1:0]          err;
  exp_t q[$];
  exp_t me;
  vec_t tbl[7];
  int checks = 0, errors = 0, cyc = 0, vcnt = 0, mnv, midx;
  int dly[N], svc[N];
  logic [31:0] rd[N];
  logic srdy, prev_rdy = 0;
  logic [N*REQ_W-1:0] mmask;

  split_reg #(.N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_resp(m_resp),
    .s_req(s_req), .s_resp(s_resp), .err_clr(err_clr), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [REQ_W-1:0] act, input logic [REQ_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // slave models: answer after dly valid cycles (-1 = never); idle slots drive ready=1 as noise
  always @(negedge clk)
    for (int i = 0; i < N; i++) begin
      if (s_req[i*REQ_W + REQ_W-1]) begin
        svc[i]++;
        srdy = dly[i] >= 0 && svc[i] - 1 == dly[i];
      end else begin
        svc[i] = 0;
        srdy = 1'b1;
      end
      s_resp[i*RESP_W +: RESP_W] = {rd[i], srdy};
    end

  always @(negedge clk)
    if (!rst_n) begin
      vcnt = 0;
      prev_rdy = 0;
    end else begin
      mnv = 0; midx = -1; mmask = '0;
      for (int i = 0; i < N; i++)
        if (s_req[i*REQ_W + REQ_W-1]) begin mnv++; midx = i; end
      if (mnv != 0) begin
        vcnt++;
        mmask[midx*REQ_W +: REQ_W] = '1;
        chk("sreq_expected", REQ_W'(q.size() != 0), 1);
        chk("sreq_count", REQ_W'(mnv), 1);
        if (q.size() != 0) begin
          chk("sreq_slot", REQ_W'(midx), REQ_W'(q[0].slot));
          chk("sreq_fields", s_req[midx*REQ_W +: REQ_W], q[0].req);
        end
      end
      chk("sreq_others_zero", REQ_W'((s_req & ~mmask) != 0), 0);
      if (m_resp[0]) begin
        chk("ready_single_cycle", REQ_W'(prev_rdy), 0);
        chk("ready_no_slave_valid", REQ_W'(mnv), 0);
        chk("ready_expected", REQ_W'(q.size() != 0), 1);
        if (q.size() != 0) begin
          me = q.pop_front();
          chk("rdata", m_resp[RESP_W-1:1], me.rdata);
          chk("ready_cycle", REQ_W'(cyc), REQ_W'(me.cyc));
          chk("slave_valid_cycles", REQ_W'(vcnt), REQ_W'(me.vc));
          chk("err_at_ready", err, me.err);
        end
        vcnt = 0;
      end else chk("resp_idle_zero", m_resp, 0);
      prev_rdy = m_resp[0];
    end

  task automatic start(input vec_t v, input int extra);
    exp_t e;
    if (v.slot >= 0) begin dly[v.slot] = v.dly; rd[v.slot] = v.rdata; end
    m_req = {1'b1, v.addr, v.wdata, v.wstrb};
    e.slot  = v.slot;
    e.req   = m_req;
    e.rdata = v.slot < 0 ? 32'h0 : (v.dly < 0 || v.dly >= TO) ? 32'hFFFF_FFFF : v.rdata;
    e.err   = v.exp_err;
    e.cyc   = cyc + v.lat + extra;
    e.vc    = v.vc;
    q.push_back(e);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!m_resp[0] && n < 50);
    chk({name, "_ready_seen"}, REQ_W'(m_resp[0]), 1);
    if (!m_resp[0]) q.delete();
  endtask

  task automatic run_row(input vec_t v);
    start(v, 0);
    wait_ready("row");
    m_req = '0;
    @(negedge clk);
    chk("err_sticky", err, v.exp_err);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("err_cleared", err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t b0, b1, rv, pv;
    for (int i = 0; i < N; i++) begin dly[i] = -1; rd[i] = '0; svc[i] = 0; end
    tbl[0] = '{32'h4000_0010, 32'h0,         4'h0, 1,  2, 32'hCAFE_0001, 2'b00, 4, 3};
    tbl[1] = '{32'h0000_0004, 32'h1234_5678, 4'hF, 0,  0, 32'hA5A5_0000, 2'b00, 2, 1};
    tbl[2] = '{32'hC000_0000, 32'h0,         4'h0, -1, 0, 32'h0,         2'b01, 1, 0};
    tbl[3] = '{32'h8000_0020, 32'h0,         4'h0, 2, -1, 32'h0,         2'b10, 9, 8};
    tbl[4] = '{32'h8000_0000, 32'h0,         4'h0, 2,  7, 32'h7777_0007, 2'b00, 9, 8};
    tbl[5] = '{32'h4000_0000, 32'h0,         4'h0, 1,  5, 32'h5555_1111, 2'b00, 7, 6};
    tbl[6] = '{32'h7FFF_FFFC, 32'hDEAD_BEEF, 4'h3, 1,  1, 32'h0102_0304, 2'b00, 3, 2};
    b0 = '{32'h0000_0100, 32'h11,        4'h1, 0, 1, 32'h0B0B_0000, 2'b00, 3, 2};
    b1 = '{32'h4000_0200, 32'h22,        4'h2, 1, 0, 32'h0C0C_0001, 2'b00, 2, 1};
    rv = '{32'h4000_0040, 32'h0,         4'h0, 1, -1, 32'h0,        2'b00, 9, 8};
    pv = '{32'h0000_0008, 32'h33,        4'hC, 0, 1, 32'h600D_0000, 2'b00, 3, 2};
    repeat (3) @(negedge clk);
    chk("reset_sreq", REQ_W'(s_req != 0), 0);
    chk("reset_mresp", m_resp, 0);
    chk("reset_err", err, 0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) run_row(tbl[i]);
    // back-to-back: master keeps valid high and swaps fields during the ready cycle
    start(b0, 0);
    wait_ready("b2b_first");
    start(b1, 1);
    wait_ready("b2b_second");
    m_req = '0;
    @(negedge clk);
    // asynchronous reset while a request to slave1 is outstanding
    start(rv, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_sreq", REQ_W'(s_req != 0), 0);
    chk("async_rst_mresp", m_resp, 0);
    chk("async_rst_err", err, 0);
    q.delete();
    m_req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_row(pv);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
